// File: rtl/run_sequencer_pkg.sv
// run_sequencer_pkg: shared types and default constants for the run sequencer.
//   seq_state_t  - sequencer FSM state encoding
//   *_DEFAULT    - default values for the top-level parameters
package run_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    WAIT,
    DRAIN
  } seq_state_t;

  localparam int N_IN_DEFAULT     = 8;
  localparam int N_OUT_DEFAULT    = 8;
  localparam int IN_BASE_DEFAULT  = 0;
  localparam int OUT_BASE_DEFAULT = 32;
  localparam int TIMEOUT_DEFAULT  = 4096;

endpackage

// File: rtl/run_sequencer_watchdog_cnt.sv
// watchdog_cnt: up-counter bounding how long the sequencer waits for the core.
//   clk, reset - clock, async active-high reset
//   clear      - synchronous clear to 0 (wins over enable)
//   enable     - count one cycle
//   tc         - count currently equals TIMEOUT-1
module watchdog_cnt #(
  parameter int TIMEOUT = 16,
  parameter int W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  // Terminal is a combinational compare on the current value, so the WAIT
  // cycle that sees TIMEOUT-1 is the last one: exactly TIMEOUT WAIT cycles.
  assign tc = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: loads operand bytes into data memory, releases the core,
// waits (bounded) for completion, then streams result bytes out.
//   clk, reset            - clock, async active-high reset
//   start                 - single-cycle run request (honoured in IDLE only)
//   in_valid/in_data/in_ready    - operand byte stream
//   core_rst/core_req/core_done  - processor control handshake
//   mem_wr_en/mem_addr/mem_wdata/mem_rdata - data-memory port (rdata comb.)
//   out_valid/out_data/out_ready - result byte stream
//   busy                  - run in progress
//   timeout               - sticky: last run abandoned waiting for core
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int N_IN     = N_IN_DEFAULT,
  parameter int N_OUT    = N_OUT_DEFAULT,
  parameter int IN_BASE  = IN_BASE_DEFAULT,
  parameter int OUT_BASE = OUT_BASE_DEFAULT,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       core_rst,
  output logic       core_req,
  input  logic       core_done,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       timeout
);

  localparam int CNT_MAX = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [7:0] IN_BASE8  = 8'(IN_BASE);
  localparam logic [7:0] OUT_BASE8 = 8'(OUT_BASE);

  seq_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          timeout_nxt;
  logic          wd_clr, wd_en, wd_tc;

  watchdog_cnt #(.TIMEOUT(TIMEOUT), .W(TW)) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clr),
    .enable (wd_en),
    .tc     (wd_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_nxt = timeout;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    in_ready    = 1'b0;
    core_req    = 1'b0;
    core_rst    = 1'b1;
    mem_wr_en   = 1'b0;
    mem_addr    = IN_BASE8;
    mem_wdata   = 8'h00;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    busy        = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt   = LOAD;
          timeout_nxt = 1'b0;
          cnt_nxt     = '0;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        mem_addr = IN_BASE8 + 8'(cnt);
        if (in_valid) begin
          mem_wr_en = 1'b1;
          mem_wdata = in_data;
          if (cnt == CW'(N_IN - 1)) begin
            state_nxt = REQ;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      REQ: begin
        core_req  = 1'b1;
        core_rst  = 1'b0;
        wd_clr    = 1'b1;
        state_nxt = WAIT;
      end

      WAIT: begin
        core_rst = 1'b0;
        // done wins over the terminal count in the same cycle
        if (core_done) begin
          state_nxt = DRAIN;
        end else begin
          wd_en = 1'b1;
          if (wd_tc) begin
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end

      DRAIN: begin
        out_valid = 1'b1;
        mem_addr  = OUT_BASE8 + 8'(cnt);
        out_data  = mem_rdata;
        if (out_ready) begin
          if (cnt == CW'(N_OUT - 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter N_IN, default 8: operand bytes written before each run.
REQ-002 Parameter N_OUT, default 8: result bytes read after each run.
REQ-003 Parameter IN_BASE, default 0: data-memory address of the first operand byte.
REQ-004 Parameter OUT_BASE, default 32: data-memory address of the first result byte.
REQ-005 Parameter TIMEOUT, default 4096: maximum WAIT cycles before the run is abandoned.
REQ-006 Ports SHALL be as follows, one clock; reset is asynchronous and active-high:
  clk  in  1  clock
  reset  in  1  async active-high reset
  start  in  1  single-cycle run request
  in_valid  in  1  operand byte valid
  in_data  in  8  operand byte
  in_ready  out  1  operand byte accepted
  core_rst  out  1  processor reset hold
  core_req  out  1  processor run request
  core_done  in  1  processor completion level
  mem_wr_en  out  1  data-memory write strobe
  mem_addr  out  8  data-memory address
  mem_wdata  out  8  data-memory write data
  mem_rdata  in  8  data-memory combinational read data
  out_valid  out  1  result byte valid
  out_data  out  8  result byte
  out_ready  in  1  result byte taken
  busy  out  1  run in progress
  timeout  out  1  sticky: last run timed out

Function
REQ-007 The FSM SHALL have the states IDLE, LOAD, REQ, WAIT and DRAIN.
REQ-008 IDLE: a start pulse SHALL cause the next state LOAD, clear timeout, and clear the byte counter. In every other state, start SHALL be ignored.
REQ-009 LOAD: in_ready=1. A byte is accepted when in_valid&in_ready; the accept cycle SHALL drive mem_wr_en=1, mem_addr=IN_BASE+cnt and mem_wdata=in_data, then increment cnt.
REQ-010 LOAD: on accepting byte N_IN-1, the next state SHALL be REQ, with cnt cleared.
REQ-011 REQ: a single state cycle. core_req=1 for exactly that cycle; the next state SHALL be WAIT, with the timeout counter cleared.
REQ-012 WAIT: core_done SHALL be sampled only in WAIT; core_done during REQ SHALL be ignored.
REQ-013 WAIT: if core_done=1, the next state SHALL be DRAIN. Otherwise the timeout counter increments, and when it reaches TIMEOUT-1 then timeout:=1 and the next state SHALL be IDLE.
REQ-014 WAIT: core_done and the terminal count in the same cycle SHALL resolve to DRAIN, with timeout staying 0.
REQ-015 DRAIN: out_valid=1, mem_addr=OUT_BASE+cnt, out_data=mem_rdata (same cycle). When out_ready=1, cnt SHALL increment.
REQ-016 DRAIN: on handing off byte N_OUT-1, the next state SHALL be IDLE. A stalled out_ready SHALL hold address and data stable.
REQ-017 core_rst=1 in IDLE, LOAD and DRAIN; core_rst=0 in REQ and WAIT.
REQ-018 busy=1 in every state except IDLE.
REQ-019 mem_wr_en SHALL be 0 outside LOAD-accept cycles. mem_addr SHALL be IN_BASE in IDLE/REQ/WAIT.
REQ-020 Address arithmetic SHALL be 8-bit modulo-256 (wraps silently). cnt width SHALL be ceil(log2(max(N_IN,N_OUT)+1)). Timeout counter width SHALL be ceil(log2(TIMEOUT)).
REQ-021 Latency: start to first in_ready SHALL be 1 cycle. Last operand accept to core_req SHALL be 1 cycle. core_done sampled to first out_valid SHALL be 1 cycle.

Reset
REQ-022 reset SHALL asynchronously force: state=IDLE, cnt=0, timeout counter=0, timeout=0.
REQ-023 While in reset, outputs SHALL be: core_req=0, core_rst=1, mem_wr_en=0, in_ready=0, out_valid=0, busy=0, out_data=mem_rdata-independent 0.
REQ-024 Reset mid-run SHALL abandon the run with no further memory writes; the first post-reset cycle is IDLE.

Structure
REQ-025 A shared package SHALL hold the state enum (seq_state_t) and the default constants N_IN, N_OUT, IN_BASE, OUT_BASE and TIMEOUT.
REQ-026 The timeout counter SHALL be one sub-module, watchdog_cnt (clear, enable, terminal-count output); the rest is flat.

Verification
REQ-027 Scenario: start; 8 bytes 0x10..0x17 back-to-back -> writes to addr 0..7 on consecutive cycles, then core_req high for exactly 1 cycle.
REQ-028 Scenario: core_done rises 20 cycles after core_req; memory preloaded 32..39=0xA0..0xA7 -> out_data=0xA0..0xA7 in order; busy falls after last handoff.
REQ-029 Scenario: TIMEOUT=16, core_done never asserts -> return to IDLE after 16 WAIT cycles, timeout=1; next start clears it.
REQ-030 Scenario: out_ready toggles 1/0 during DRAIN -> each byte held until taken, none lost or duplicated.
REQ-031 Scenario: start pulsed during WAIT; core_done=1 during REQ -> both ignored, run proceeds normally.
REQ-032 Scenario: reset asserted after 3 operand bytes -> immediately IDLE, mem_wr_en=0, core_rst=1; a fresh run then starts at addr IN_BASE.
